// File: rtl/mac_dot_seq_if.sv
// Port bundle of the dot-product sequencer: job start, element stream, result and the mac operand bus.
// master = surrounding environment, slave = sequencer.
interface mac_dot_seq_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] init;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] mac_a;
  logic [WIDTH-1:0] mac_b;
  logic [WIDTH-1:0] mac_c;
  logic [WIDTH-1:0] mac_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             busy;

  modport master (
    output start_valid, len, init, in_valid, in_a, in_b, mac_out, res_ready,
    input  start_ready, in_ready, mac_a, mac_b, mac_c, res_valid, res_data, busy
  );

  modport slave (
    input  start_valid, len, init, in_valid, in_a, in_b, mac_out, res_ready,
    output start_ready, in_ready, mac_a, mac_b, mac_c, res_valid, res_data, busy
  );
endinterface

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer around a shared fp16 mac (out = a*b + c), accumulator fed back as c.
// Optional macro MAC_ZERO_SKIP_EN: pairs with a finite-times-zero product bypass the mac in one cycle.
module mac_dot_seq #(
  parameter int WIDTH   = 16,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  mac_dot_seq_if.slave  bus
);
  localparam int TIMER_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [WIDTH-1:0]   mac_a_q, mac_a_d;
  logic [WIDTH-1:0]   mac_b_q, mac_b_d;
  logic [WIDTH-1:0]   mac_c_q, mac_c_d;
  logic [LEN_W-1:0]   cnt_inc;
  logic               last_elem;
  logic               timer_last;
  logic               skip;

`ifdef MAC_ZERO_SKIP_EN
  function automatic logic is_zero(input logic [WIDTH-1:0] x);
    return x[WIDTH-2:0] == '0;
  endfunction

  function automatic logic is_inf_nan(input logic [WIDTH-1:0] x);
    return x[14:10] == 5'h1F;
  endfunction

  // A zero times anything finite cannot change the sum (up to the sign of zero).
  assign skip = (is_zero(bus.in_a) && !is_inf_nan(bus.in_b)) ||
                (is_zero(bus.in_b) && !is_inf_nan(bus.in_a));
`else
  assign skip = 1'b0;
`endif

  assign cnt_inc    = cnt_q + LEN_W'(1);
  assign last_elem  = (cnt_inc == len_q);
  assign timer_last = (timer_q == TIMER_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      timer_q <= '0;
      mac_a_q <= '0;
      mac_b_q <= '0;
      mac_c_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      timer_q <= timer_d;
      mac_a_q <= mac_a_d;
      mac_b_q <= mac_b_d;
      mac_c_q <= mac_c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_valid) state_d = (bus.len == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (bus.in_valid) begin
        if (skip) state_d = last_elem ? S_DONE : S_FETCH;
        else      state_d = S_WAIT;
      end
      S_WAIT:  if (timer_last) state_d = last_elem ? S_DONE : S_FETCH;
      S_DONE:  if (bus.res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates; mac operand registers hold until the next issued pair.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    timer_d = timer_q;
    mac_a_d = mac_a_q;
    mac_b_d = mac_b_q;
    mac_c_d = mac_c_q;
    case (state_q)
      S_IDLE: if (bus.start_valid) begin
        len_d = bus.len;
        acc_d = bus.init;
        cnt_d = '0;
      end
      S_FETCH: if (bus.in_valid) begin
        if (skip) begin
          cnt_d = cnt_inc;
        end else begin
          mac_a_d = bus.in_a;
          mac_b_d = bus.in_b;
          mac_c_d = acc_q;
          timer_d = TIMER_W'(MAC_LAT);
        end
      end
      S_WAIT: begin
        timer_d = timer_q - TIMER_W'(1);
        if (timer_last) begin
          acc_d = bus.mac_out;
          cnt_d = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.start_ready = (state_q == S_IDLE);
    bus.in_ready    = (state_q == S_FETCH);
    bus.res_valid   = (state_q == S_DONE);
    bus.busy        = (state_q != S_IDLE);
    bus.res_data    = (state_q == S_DONE) ? acc_q : '0;
    bus.mac_a       = mac_a_q;
    bus.mac_b       = mac_b_q;
    bus.mac_c       = mac_c_q;
  end
endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
- Sequencer that drives the shared fp16 `mac` unit (out = a*b + c) to compute a dot product.
- Accepts a job (length plus an initial accumulator), then streams element pairs from a valid/ready source.
- Feeds each pair into the MAC with the running accumulator as `c`, waits out the MAC latency, and captures the result back into the accumulator.
- Presents the final fp16 sum on a valid/ready result port. Sits between the vector operand buffers and the single `mac` instance.

Parameters:
- WIDTH, 16, operand/result width (IEEE half precision).
- LEN_W, 8, width of the job length field (max 2^LEN_W-1 elements).
- MAC_LAT, 2, number of clk edges from MAC operands changing to mac_out valid (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  job request.
- start_ready  out  1  high only in IDLE.
- len  in  LEN_W  element count, sampled at the start handshake.
- init  in  WIDTH  initial accumulator, sampled at the start handshake.
- in_valid  in  1  element pair available.
- in_ready  out  1  high only in FETCH.
- in_a  in  WIDTH  vector A element.
- in_b  in  WIDTH  vector B element.
- mac_a  out  WIDTH  to mac.a (registered).
- mac_b  out  WIDTH  to mac.b (registered).
- mac_c  out  WIDTH  to mac.c (registered).
- mac_out  in  WIDTH  from mac.out.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_data  out  WIDTH  final accumulator.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: state=IDLE; acc, cnt, timer, mac_a, mac_b, mac_c, res_data = 0; res_valid=0; busy=0; start_ready=1; in_ready=0.
- Reset mid-job aborts immediately; any in-flight MAC result is discarded and no partial result is emitted.
- IDLE:
  - start_ready=1.
  - On start_valid: latch len, set acc<=init, cnt<=0.
  - len==0 → DONE; otherwise → FETCH.
- FETCH:
  - in_ready=1.
  - On in_valid: mac_a<=in_a, mac_b<=in_b, mac_c<=acc, timer<=MAC_LAT → WAIT.
  - Without in_valid, stays in FETCH indefinitely.
- WAIT:
  - timer decrements each edge.
  - On the edge where timer==1: acc<=mac_out, cnt<=cnt+1.
  - Then if cnt+1==len → DONE, else → FETCH.
  - mac_a/b/c hold their values throughout WAIT and are not cleared after capture.
- DONE:
  - res_valid=1, res_data=acc; both stable until res_ready.
  - On res_ready → IDLE (res_valid low the next cycle).
  - Back-to-back jobs: start_ready rises the cycle after the result handshake; no job is accepted while in DONE.
- Latency: with in_valid held high, res_valid asserts 1+len*(1+MAC_LAT) cycles after the start handshake edge. For len=0 it asserts 1 cycle after.
- Arithmetic: all fp16 arithmetic (rounding, special values) is performed by mac; the sequencer never modifies values.
- cnt is LEN_W wide and cannot wrap, because cnt<len ≤ 2^LEN_W-1.
- Simultaneous start_valid and in_valid in IDLE: the element is not consumed (in_ready=0).

Optional Feature:
- Macro MAC_ZERO_SKIP_EN.
- Defined: in FETCH, a pair is skipped when either operand is ±0 (bits[14:0]==0) and the other operand's exponent != 5'h1F.
  - The pair is accepted (in_ready=1); mac registers and acc are unchanged; cnt increments.
  - Next state is DONE if cnt+1==len, else FETCH. Each skipped element costs 1 cycle.
  - The sign of a zero accumulator may differ from strict IEEE; this is accepted.
- Undefined: every pair is issued to the MAC with full latency.

Test Plan:
- Reset, then len=2, init=0000, pairs (3C00,4000),(4000,4200), behavioural mac with MAC_LAT=2 → res_data=4800 (8.0), res_valid 7 cycles after start; mac_c sequence 0000 then 4000.
- len=1, init=3C00, pair (4000,4200) → res_data=4700 (7.0), res_valid 4 cycles after start.
- len=0, init=3800 → res_valid 1 cycle after start, res_data=3800; in_ready never asserted.
- len=3, init=0000, pairs all (3C00,3C00) with in_valid dropped for 5 cycles before the 2nd element → res_data=4200; FETCH stalls with mac_a/b/c held; res_ready held low 4 cycles keeps res_valid/res_data stable.
- Assert rst for 1 cycle during WAIT of the 2nd element of a len=3 job → all outputs return to reset values; a new job len=1 (4000,4000), init=0000 → res_data=4400.
- With MAC_ZERO_SKIP_EN: len=2, pairs (0000,4200),(3C00,4000), init=0000 → res_data=4000, latency 1+1+3=5 cycles. Without the macro: same result, latency 7 cycles.
